// File: rtl/button_input_conditioner.sv
// button_input_conditioner: per-button synchronize, debounce, single-pulse, auto-repeat and hold-level enables
module button_input_conditioner #(
  parameter int N_BTN = 4,
  parameter int DB_CYCLES = 250000,
  parameter int HOLD_CYCLES = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] DPBs,
  output logic [N_BTN-1:0] SCENs,
  output logic [N_BTN-1:0] MCENs,
  output logic [N_BTN-1:0] CCENs
);
  localparam int MAX_C = (DB_CYCLES > HOLD_CYCLES)
                         ? ((DB_CYCLES > REPEAT_CYCLES) ? DB_CYCLES : REPEAT_CYCLES)
                         : ((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, DB_PRESS, PULSE, HELD, REPEAT, DB_RELEASE} state_t;
  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    state_t state, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic s1, sync, rep, dpb, scen, mcen, ccen;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        {s1, sync, dpb, scen, mcen, ccen} <= '0;
        state <= IDLE;
        cnt <= '0;
      end else begin
        s1 <= btn_in[g];
        sync <= s1;
        state <= nxt;
        cnt <= cnt_nxt;
        dpb <= nxt inside {PULSE, HELD, REPEAT, DB_RELEASE};
        scen <= nxt == PULSE;
        mcen <= nxt == PULSE || rep;
        ccen <= nxt == REPEAT;
      end
    // Outputs are registered from next state, so every pulse lines up with the state it belongs to.
    always_comb begin
      nxt = state;
      cnt_nxt = cnt + CNT_W'(1);
      rep = 1'b0;
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          nxt = sync ? DB_PRESS : IDLE;
        end
        DB_PRESS:
          if (!sync) nxt = IDLE;
          else if (cnt == DB_LAST) nxt = PULSE;
        PULSE: begin
          nxt = HELD;
          cnt_nxt = '0;
        end
        HELD:
          if (!sync) begin
            nxt = DB_RELEASE;
            cnt_nxt = '0;
          end else if (cnt == HOLD_LAST) begin
            nxt = REPEAT;
            cnt_nxt = '0;
            rep = 1'b1;
          end
        REPEAT:
          if (!sync) begin
            nxt = DB_RELEASE;
            cnt_nxt = '0;
          end else if (cnt == REP_LAST) begin
            cnt_nxt = '0;
            rep = 1'b1;
          end
        DB_RELEASE:
          if (sync) begin
            nxt = HELD;
            cnt_nxt = '0;
          end else if (cnt == DB_LAST) nxt = IDLE;
        default: begin
          nxt = IDLE;
          cnt_nxt = '0;
        end
      endcase
    end
    assign DPBs[g] = dpb;
    assign SCENs[g] = scen;
    assign MCENs[g] = mcen;
    assign CCENs[g] = ccen;
  end
endmodule

// File: tb/tb_button_input_conditioner.sv
// tb_button_input_conditioner: table-driven scoreboard bench, DB=4 HOLD=8 REPEAT=3
module tb_button_input_conditioner;
  logic clk = 1'b0;
  logic reset_n;
  logic [3:0] btn_in, DPBs, SCENs, MCENs, CCENs;
  int checks = 0;
  int passed = 0;
  typedef struct {
    logic [3:0] btn;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[$];
  logic [15:0] sb[$];
  always #5 clk = ~clk;
  button_input_conditioner #(
    .N_BTN(4), .DB_CYCLES(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_in),
    .DPBs(DPBs), .SCENs(SCENs), .MCENs(MCENs), .CCENs(CCENs)
  );
  // {btn, dpb, scen, mcen, ccen} for scenario kind at step i (step i drives the edge Ei)
  function automatic logic [4:0] exp_bit(int kind, int i);
    case (kind)
      1: return {i < 12, i >= 6 && i <= 17, i == 6, i == 6, 1'b0};
      2: return {i < 6 && i != 2, 4'b0};
      3: return {i < 30, i >= 6 && i <= 35, i == 6,
                 i == 6 || (i >= 15 && i <= 30 && (i - 15) % 3 == 0), i >= 15 && i <= 31};
      4: return {i < 10 || (i >= 12 && i < 28), i >= 6 && i <= 33, i == 6,
                 i == 6 || i == 22 || i == 25 || i == 28, i >= 22 && i <= 29};
      5: return {1'b1, i >= 6, i == 6, i == 6 || (i >= 15 && (i - 15) % 3 == 0), i >= 15};
      default: return 5'b0;
    endcase
  endfunction
  function automatic vec_t make_vec(int k0, int k1, int k2, int k3, int i);
    vec_t v;
    int kinds[4];
    logic [4:0] r;
    kinds = '{k0, k1, k2, k3};
    v.btn = '0;
    v.exp = '0;
    for (int b = 0; b < 4; b++) begin
      r = exp_bit(kinds[b], i);
      v.btn[b] = r[4];
      v.exp[12+b] = r[3];
      v.exp[8+b] = r[2];
      v.exp[4+b] = r[1];
      v.exp[b] = r[0];
    end
    return v;
  endfunction
  task automatic add_seg(int k0, int k1, int k2, int k3, int len);
    for (int i = 0; i < len; i++) tbl.push_back(make_vec(k0, k1, k2, k3, i));
  endtask
  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got dpb/scen/mcen/ccen=%h, expected %h", name, got, exp);
  endtask
  task automatic step(logic [3:0] b, logic [15:0] e, string name);
    logic [15:0] exp;
    @(negedge clk);
    btn_in = b;
    sb.push_back(e);
    @(posedge clk);
    #2;
    exp = sb.pop_front();
    check(name, {DPBs, SCENs, MCENs, CCENs}, exp);
  endtask
  initial begin
    reset_n = 1'b0;
    btn_in = 4'hF;
    repeat (3) @(posedge clk);
    #2;
    check("reset_state", {DPBs, SCENs, MCENs, CCENs}, 16'h0);
    btn_in = 4'h0;
    @(negedge clk);
    reset_n = 1'b1;
    add_seg(1, 0, 0, 0, 20);
    add_seg(0, 2, 0, 0, 12);
    add_seg(0, 0, 3, 4, 40);
    add_seg(5, 0, 0, 0, 20);
    foreach (tbl[i]) step(tbl[i].btn, tbl[i].exp, $sformatf("vec%0d", i));
    #1 reset_n = 1'b0;
    #1 check("async_reset", {DPBs, SCENs, MCENs, CCENs}, 16'h0);
    @(posedge clk);
    #2 check("reset_hold", {DPBs, SCENs, MCENs, CCENs}, 16'h0);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      vec_t v;
      v = make_vec(5, 0, 0, 0, i);
      step(v.btn, v.exp, $sformatf("post_reset%0d", i));
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
